ndp_result_packer: RTL

//  Downstream of the NDP core's result stream. Accepts 64-bit AXI4-Stream beats (4 x fp16 results each)
//  and packs them into 512-bit beats. The output carries a byte keep and a last flag for the HBM write

---
 rtl/ndp_result_packer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ndp_result_packer.sv
// ndp_result_packer
// Packs narrow NDP result beats (lane 0 first) into wide output words with a
// byte keep and a last flag, buffered by a small output FIFO so that memory
// backpressure does not stall the core until the FIFO is full.
module ndp_result_packer #(
  parameter int C_IN_WIDTH  = 64,
  parameter int C_OUT_WIDTH = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic [C_IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [C_OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [C_OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     packet_done,
  output logic [31:0]              word_count
);

  localparam int R  = C_OUT_WIDTH / C_IN_WIDTH;
  localparam int KW = C_OUT_WIDTH / 8;
  localparam int LB = C_IN_WIDTH / 8;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IW-1:0]          idx_q, idx_d;
  logic [C_OUT_WIDTH-1:0] acc_q, acc_d;
  logic [C_OUT_WIDTH-1:0] word_d;
  logic [KW-1:0]          keep_d;

  logic [C_OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [KW-1:0]          mem_keep [FIFO_DEPTH];
  logic                   mem_last [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          packet_done_q, packet_done_d;
  logic [31:0]   word_count_q, word_count_d;

  logic full, empty, in_fire, lane_end, push, pop;

  // Ready depends only on the registered occupancy (never on m_axis_tready);
  // it is also held low while reset is applied.
  assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  assign s_axis_tready = ~full & ~axi_areset;
  assign in_fire       = s_axis_tvalid & s_axis_tready;
  assign lane_end      = (idx_q == IW'(R - 1)) | s_axis_tlast;
  assign push          = in_fire & lane_end;

  // Head of FIFO drives the master side; outputs read as zero while empty.
  assign m_axis_tvalid = ~empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = empty ? '0 : mem_data[rd_ptr_q];
  assign m_axis_tkeep  = empty ? '0 : mem_keep[rd_ptr_q];
  assign m_axis_tlast  = empty ? 1'b0 : mem_last[rd_ptr_q];
  assign packet_done   = packet_done_q;
  assign word_count    = word_count_q;

  // Merge the incoming beat into the accumulator and build the lane keep mask.
  always_comb begin
    word_d = acc_q;
    word_d[idx_q*C_IN_WIDTH +: C_IN_WIDTH] = s_axis_tdata;
    keep_d = '0;
    for (int l = 0; l < R; l++) begin
      if (l <= int'(idx_q)) keep_d[l*LB +: LB] = '1;
    end
    idx_d = idx_q;
    acc_d = acc_q;
    if (in_fire) begin
      if (lane_end) begin
        idx_d = '0;
        acc_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
        acc_d = word_d;
      end
    end
  end

  // FIFO pointer/occupancy and downstream statistics next-state.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + AW'(push);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    packet_done_d = pop & m_axis_tlast;
    word_count_d  = word_count_q + 32'(pop);
  end

  // State registers; reset discards any partial word and all queued words.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      idx_q         <= '0;
      acc_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      packet_done_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      packet_done_q <= packet_done_d;
      word_count_q  <= word_count_d;
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated head.
  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= word_d;
      mem_keep[wr_ptr_q] <= keep_d;
      mem_last[wr_ptr_q] <= s_axis_tlast;
    end
  end

endmodule
